// File: rtl/des_pkg.sv
// Shared DES constants for the decrypt core: permutation tables, S-boxes,
// the reverse key-rotation schedule, FSM state type and permutation helpers.
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Tables use DES numbering: entry value 1 is the MSB of the source word.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Right-rotation amount before round r when walking subkeys K16 down to K1.
  localparam logic [1:0] ROT_SCHED [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Each S-box packed row-major: entry (row*16+col) is nibble 0 at the MSB end.
  localparam logic [255:0] SBOX_TBL [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TBL[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TBL[i]];
    return y;
  endfunction

  // Parity bits 8,16..64 are simply never selected.
  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TBL[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TBL[i]];
    return y;
  endfunction

  function automatic logic [27:0] rot_right(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Outer bits select the row, inner four the column.
  function automatic logic [3:0] sbox_lookup(input int idx, input logic [5:0] x);
    int k;
    k = int'({x[5], x[0], x[4:1]});
    return SBOX_TBL[idx][(63-k)*4 +: 4];
  endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K) = P(S(E(R) ^ K)); no registers inside.
module des_f_function
  import des_pkg::*;
(
  input  logic [31:0] i_r,
  input  logic [47:0] i_subkey,
  output logic [31:0] o_f
);

  logic [47:0] w_mixed;
  logic [31:0] w_sbox_out;

  assign w_mixed = e_expand(i_r) ^ i_subkey;

  des_sbox #(.IDX(0)) S_Box_1 (.i_bits(w_mixed[47:42]), .o_bits(w_sbox_out[31:28]));
  des_sbox #(.IDX(1)) S_Box_2 (.i_bits(w_mixed[41:36]), .o_bits(w_sbox_out[27:24]));
  des_sbox #(.IDX(2)) S_Box_3 (.i_bits(w_mixed[35:30]), .o_bits(w_sbox_out[23:20]));
  des_sbox #(.IDX(3)) S_Box_4 (.i_bits(w_mixed[29:24]), .o_bits(w_sbox_out[19:16]));
  des_sbox #(.IDX(4)) S_Box_5 (.i_bits(w_mixed[23:18]), .o_bits(w_sbox_out[15:12]));
  des_sbox #(.IDX(5)) S_Box_6 (.i_bits(w_mixed[17:12]), .o_bits(w_sbox_out[11:8]));
  des_sbox #(.IDX(6)) S_Box_7 (.i_bits(w_mixed[11:6]),  .o_bits(w_sbox_out[7:4]));
  des_sbox #(.IDX(7)) S_Box_8 (.i_bits(w_mixed[5:0]),   .o_bits(w_sbox_out[3:0]));

  assign o_f = p_perm(w_sbox_out);

endmodule

// File: rtl/des_sbox.sv
// One DES S-box: 6-bit input to 4-bit output, purely combinational.
module des_sbox
  import des_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [5:0] i_bits,
  output logic [3:0] o_bits
);

  assign o_bits = sbox_lookup(IDX, i_bits);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative single-DES decryption: one Feistel round per clock, subkeys
// K16..K1 produced on the fly by right-rotating C/D, valid/ready on both sides.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_init;
  logic [3:0]  r_round;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [63:0] r_out_data;

  logic        w_accept;
  logic        w_last_round;
  logic [27:0] w_c_rot;
  logic [27:0] w_d_rot;
  logic [47:0] w_subkey;
  logic [31:0] w_f;
  logic [31:0] w_r_next;

  assign w_accept     = in_valid && in_ready;
  assign w_last_round = (r_round == 4'd15);

  assign w_c_rot  = rot_right(r_c, ROT_SCHED[r_round]);
  assign w_d_rot  = rot_right(r_d, ROT_SCHED[r_round]);
  assign w_subkey = pc2_perm({w_c_rot, w_d_rot});
  assign w_r_next = r_l ^ w_f;

  des_f_function u_f (
    .i_r      (r_r),
    .i_subkey (w_subkey),
    .o_f      (w_f)
  );

  // r_init keeps in_ready low while reset is asserted and for the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_init  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      r_state <= w_next_state;
      r_init  <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no branch leaves the signal unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)     w_next_state = ROUND;
      ROUND:   if (w_last_round) w_next_state = DONE;
      DONE:    if (out_ready)    w_next_state = IDLE;
      default:                   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = r_init;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: every datapath flop is a plain register (no memory array), so all clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round    <= 4'd0;
      r_l        <= 32'h0;
      r_r        <= 32'h0;
      r_c        <= 28'h0;
      r_d        <= 28'h0;
      r_out_data <= 64'h0;
    end else if (w_accept) begin
      {r_l, r_r} <= ip_perm(in_data);
      {r_c, r_d} <= pc1_perm(in_key);
      r_round    <= 4'd0;
    end else if (r_state == ROUND) begin
      r_c     <= w_c_rot;
      r_d     <= w_d_rot;
      r_l     <= r_r;
      r_r     <= w_r_next;
      r_round <= r_round + 4'd1;
      // Halves are swapped (R16 || L16) before the final permutation.
      if (w_last_round) r_out_data <= fp_perm({w_r_next, r_r});
    end
  end

  assign out_data = r_out_data;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Self-checking bench for des_decrypt_core: known answers, backpressure,
// busy-ignore and reset cases, with a scoreboard of expected plaintexts.
module tb_des_decrypt_core;

  localparam logic [63:0] KEY1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1   = 64'h85E813540F0AB405;
  localparam logic [63:0] PT1   = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY1P = 64'h123556789ABDDEF0;
  localparam logic [63:0] KEY2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT2   = 64'h0000000000000000;
  localparam logic [63:0] PT2   = 64'h8787878787878787;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int          checks;
  int          errors;
  int          cycle;
  int          accept_cycle;
  int          acc_count;
  logic [63:0] exp_next;
  logic [63:0] sb_q [$];

  des_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock step: handshakes sampled at the falling edge, then the rising edge, then #1.
  task automatic tick();
    logic [63:0] exp;
    @(negedge clk);
    if (rst_n && in_valid && in_ready) begin
      sb_q.push_back(exp_next);
      acc_count++;
      accept_cycle = cycle;
    end
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_output: got %h, no block outstanding", out_data);
      end else begin
        exp = sb_q.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL sb_data: got %h required %h", out_data, exp);
        end
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic send(input logic [63:0] ct, input logic [63:0] key, input logic [63:0] exp);
    int n = 0;
    int start = acc_count;
    in_data  = ct;
    in_key   = key;
    exp_next = exp;
    in_valid = 1'b1;
    while (acc_count == start && n < 100) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_count == start) begin
      errors++;
      $display("FAIL send_accept_timeout: in_ready=%b after %0d cycles, required accept", in_ready, n);
    end
  endtask

  task automatic wait_out(input string name, output int lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_out_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
      lat = -1;
    end else begin
      lat = cycle - 1 - accept_cycle;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb_q.delete();
  endtask

  task automatic release_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%h, required 0 0 0",
               in_ready, out_valid, out_data);
    end
    release_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_known_answer(input string name, input logic [63:0] ct,
                                   input logic [63:0] key, input logic [63:0] pt);
    int lat;
    out_ready = 1'b1;
    send(ct, key, pt);
    wait_out(name, lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL %s_latency: got %0d required 16", name, lat);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== pt) begin
      errors++;
      $display("FAIL %s_after_handshake: out_valid=%b in_ready=%b out_data=%h, required 0 1 %h",
               name, out_valid, in_ready, out_data, pt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(CT2, KEY2, PT2);
    wait_out("backpressure", lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== PT2 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                 i, out_valid, out_data, in_ready, PT2);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int start;
    out_ready = 1'b1;
    start = acc_count;
    send(CT1, KEY1, PT1);
    tick();
    tick();
    tick();
    in_data  = CT2;
    in_key   = KEY2;
    exp_next = PT2;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: in_ready=%b during rounds, required 0", in_ready);
    end
    wait_out("busy_first", lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL busy_first_latency: got %0d required 16", lat);
    end
    tick();
    checks++;
    if (acc_count != start + 1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_early_accept: accepts=%0d in_ready=%b out_valid=%b, required 1 1 0",
               acc_count - start, in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (acc_count != start + 2) begin
      errors++;
      $display("FAIL busy_second_accept: accepts=%0d required 2", acc_count - start);
    end
    wait_out("busy_second", lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL busy_second_latency: got %0d required 16", lat);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    out_ready = 1'b1;
    send(CT1, KEY1, PT1);
    for (int i = 0; i < 7; i++) tick();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_round: out_valid=%b in_ready=%b out_data=%h, required 0 0 0",
               out_valid, in_ready, out_data);
    end
    release_reset();

    out_ready = 1'b0;
    send(CT2, KEY2, PT2);
    wait_out("reset_done", lat);
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_done: out_valid=%b out_data=%h, required 0 0", out_valid, out_data);
    end
    release_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    test_known_answer("after_reset", CT1, KEY1, PT1);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cycle        = 0;
    accept_cycle = 0;
    acc_count    = 0;
    exp_next     = 64'h0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 64'h0;
    in_key       = 64'h0;
    out_ready    = 1'b0;

    test_reset();
    test_known_answer("kat1", CT1, KEY1, PT1);
    test_known_answer("kat2", CT2, KEY2, PT2);
    test_known_answer("parity", CT1, KEY1P, PT1);
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_op();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d blocks outstanding, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
